puf_response_packer: RTL
========================

// Module: puf_response_packer
// PURPOSE
//  Downstream of the SIRC handler / PUF test stage. Accepts a stream of single-bit PUF responses
//  from the arbiter (valid/ready), packs them MSB-first into bytes and writes them to the 8K x 8
//  result RAM. Drives the RAM write port (we/waddr/din) that the SIRC handler later reads back to
//  the PC. Reports completion with a one-cycle done pulse.
// PARAMETERS
//  MEM_ADDR_WIDTH  13  result RAM address width; depth = 2**MEM_ADDR_WIDTH bytes
//  COUNT_WIDTH     16  width of the requested bit count and the internal bit counter
// PORTS
//  clk            in   1               single clock, all logic on posedge
//  reset          in   1               synchronous, active-high
//  start          in   1               1-cycle pulse: begin a run; ignored unless IDLE
//  num_bits       in   COUNT_WIDTH     response bits to collect; sampled on accepted start
//  resp_valid     in   1               response bit present
//  resp_bit       in   1               response bit value
//  resp_ready     out  1               packer accepts a bit when resp_valid & resp_ready
//  mem_we         out  1               RAM write enable, one cycle per byte
//  mem_waddr      out  MEM_ADDR_WIDTH  RAM byte address
//  mem_din        out  8               RAM write data
//  busy           out  1               high from the cycle after start until done
//  done           out  1               1-cycle pulse at end of run
//  bytes_written  out  MEM_ADDR_WIDTH+1  bytes written this run; stable after done
//  overflow       out  1               sticky: bytes dropped because RAM full; cleared on start
// BEHAVIOUR
//  - Reset: all outputs 0. State IDLE. Shift reg, counters and addr are 0.
//  - States: IDLE -> COLLECT -> (FLUSH) -> DONE -> IDLE. All outputs are registered.
//  - IDLE: start=1 latches num_bits and clears addr, bytes_written and overflow.
//    num_bits==0 -> DONE. Otherwise -> COLLECT. busy=1 from the next cycle.
//  - COLLECT: resp_ready=1. On each accepted bit: shift={shift[6:0],resp_bit}; bit_cnt++.
//    The 8th bit of a byte produces mem_we=1 in the next cycle, with mem_din=byte and
//    mem_waddr=addr. addr++ and bytes_written++ follow.
//  - Last requested bit (bit_cnt==num_bits-1) accepted: resp_ready drops the next cycle.
//    Byte complete -> write it, then DONE. Partial byte (k bits, k<8) -> FLUSH.
//  - FLUSH: writes {shift[k-1:0], (8-k) zeros} for one cycle, then DONE.
//  - DONE: done=1 for exactly one cycle, busy=0, -> IDLE. No writes occur in DONE.
//  - RAM full: after writing addr 2**MEM_ADDR_WIDTH-1, further bytes are not written
//    (mem_we stays 0) and overflow is set. Collection continues until num_bits so the
//    upstream never stalls. addr does not wrap.
//  - start while busy is ignored. reset mid-run aborts: mem_we=0 the next cycle, no done pulse.
//  - Write latency: 1 cycle after the bit that completes a byte. done follows the last write
//    by 1 cycle.
// CONFIGURATION
//  RESP_ONES_COUNT_EN defined: adds port ones_count (out, COUNT_WIDTH), the count of accepted
//  1-bits this run. Cleared on accepted start, final when done pulses. Used for bias/uniformity
//  checks in calibration.
//  Not defined: port and counter absent; all other behaviour is identical.
// STRUCTURE
//  Package puf_resp_pkg: state encoding (IDLE/COLLECT/FLUSH/DONE), default widths, RAM depth
//  constant. The byte assembler (shift reg + 3-bit index + pad logic) is a sub-module,
//  resp_byte_shifter. The FSM, address and overflow logic stay in the top module.
// TESTING
//  1. num_bits=16, bits 1010_1100 0000_1111, valid every cycle
//     -> writes 0xAC@0, 0x0F@1; bytes_written=2; done 1 cycle after 2nd write.
//  2. num_bits=11, bits 1111_0000 101 -> writes 0xF0@0, then FLUSH 0xA0@1; bytes_written=2.
//  3. num_bits=0 -> no mem_we; done pulses 2 cycles after start; busy never 1 beyond DONE.
//  4. resp_valid toggled randomly, num_bits=64, 2nd start mid-run
//     -> 8 bytes correct; 2nd start ignored; resp_ready low after bit 64.
//  5. MEM_ADDR_WIDTH=3, num_bits=80 -> 8 writes (addr 0..7), overflow=1, bytes_written=8, done.
//  6. reset asserted after 5 bits of a 16-bit run -> outputs 0 next cycle, no write, no done.
//     A new start then runs cleanly.

Source files
------------

// File: rtl/puf_resp_pkg.sv
// Shared definitions for the PUF response packer.
//   state_t          : packer FSM encoding (idle, collect, flush, done)
//   DefaultMemAddrWidth / DefaultCountWidth : default parameter values
//   RamDepth, ram_depth() : result RAM depth in bytes for a given address width
package puf_resp_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StFlush   = 2'd2,
        StDone    = 2'd3
    } state_t;

    localparam int unsigned DefaultMemAddrWidth = 13;
    localparam int unsigned DefaultCountWidth   = 16;

    function automatic int unsigned ram_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    localparam int unsigned RamDepth = ram_depth(DefaultMemAddrWidth);

endpackage

// File: rtl/resp_byte_shifter.sv
// Byte assembler for the PUF response packer. Bits enter MSB-first.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : synchronous clear of shift register and bit index (start of run)
//   shift_en     : accept bit_in this cycle
//   bit_in       : incoming response bit
//   byte_next    : byte formed if bit_in is shifted in now (valid when byte_done)
//   byte_done    : this shift completes a byte (8th bit)
//   pad_byte     : pending partial byte left-aligned, zero padded (valid when idx != 0)
module resp_byte_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       bit_in,
    output logic [7:0] byte_next,
    output logic       byte_done,
    output logic [7:0] pad_byte
);

    logic [7:0] shift;
    logic [2:0] idx;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift <= '0;
            idx   <= '0;
        end else if (shift_en) begin
            shift <= {shift[6:0], bit_in};
            // wraps to 0 after the 8th bit, so no explicit byte-boundary clear is needed
            idx   <= idx + 3'd1;
        end
    end

    always_comb begin
        byte_next = {shift[6:0], bit_in};
        byte_done = shift_en && (idx == 3'd7);
        // the k pending bits sit in shift[k-1:0]; move them to the top of the byte
        pad_byte  = shift << (4'd8 - {1'b0, idx});
    end

endmodule

// File: rtl/puf_response_packer.sv
// PUF response packer: collects single-bit responses (valid/ready), packs them
// MSB-first into bytes and writes them to the result RAM, then pulses done.
// Optional macro RESP_ONES_COUNT_EN adds the ones_count output (accepted 1-bits this run).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start          : 1-cycle run request, honoured only when idle
//   num_bits       : number of response bits to collect, sampled with start
//   resp_valid/resp_bit/resp_ready : response bit handshake
//   mem_we/mem_waddr/mem_din       : result RAM write port
//   busy, done     : run in progress, 1-cycle end-of-run pulse
//   bytes_written  : bytes stored this run
//   ones_count     : (RESP_ONES_COUNT_EN only) accepted 1-bits this run
//   overflow       : sticky, bytes dropped because the RAM was full
module puf_response_packer
    import puf_resp_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = DefaultMemAddrWidth,
    parameter int unsigned COUNT_WIDTH    = DefaultCountWidth
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [COUNT_WIDTH-1:0]    num_bits,
    input  logic                      resp_valid,
    input  logic                      resp_bit,
    output logic                      resp_ready,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]                mem_din,
    output logic                      busy,
    output logic                      done,
    output logic [MEM_ADDR_WIDTH:0]   bytes_written,
`ifdef RESP_ONES_COUNT_EN
    output logic [COUNT_WIDTH-1:0]    ones_count,
`endif
    output logic                      overflow
);

    localparam logic [MEM_ADDR_WIDTH-1:0] LastAddr =
        MEM_ADDR_WIDTH'(ram_depth(MEM_ADDR_WIDTH) - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] AddrOne = MEM_ADDR_WIDTH'(1);
    localparam logic [MEM_ADDR_WIDTH:0]   BwOne   = (MEM_ADDR_WIDTH + 1)'(1);
    localparam logic [COUNT_WIDTH-1:0]    CntOne  = COUNT_WIDTH'(1);

    state_t                    state;
    logic [COUNT_WIDTH-1:0]    num_bits_q;
    logic [COUNT_WIDTH-1:0]    bit_cnt;
    logic [MEM_ADDR_WIDTH-1:0] addr;

    logic                      accept;
    logic                      shift_clear;
    logic [COUNT_WIDTH-1:0]    bit_cnt_next;
    logic                      last_bit;
    logic                      ram_full;
    logic                      wr_req;
    logic [7:0]                wr_data;
    logic [7:0]                byte_next;
    logic [7:0]                pad_byte;
    logic                      byte_done;

    resp_byte_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .clear     (shift_clear),
        .shift_en  (accept),
        .bit_in    (resp_bit),
        .byte_next (byte_next),
        .byte_done (byte_done),
        .pad_byte  (pad_byte)
    );

    always_comb begin
        accept       = (state == StCollect) && resp_valid && resp_ready;
        shift_clear  = (state == StIdle) && start;
        bit_cnt_next = bit_cnt + CntOne;
        last_bit     = (bit_cnt_next == num_bits_q);
        // every byte written this run bumps bytes_written, so its MSB marks a full RAM
        ram_full     = bytes_written[MEM_ADDR_WIDTH];
        wr_req       = 1'b0;
        wr_data      = byte_next;
        if (accept && byte_done) begin
            wr_req = 1'b1;
        end else if (state == StFlush) begin
            wr_req  = 1'b1;
            wr_data = pad_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            num_bits_q    <= '0;
            bit_cnt       <= '0;
            addr          <= '0;
            resp_ready    <= 1'b0;
            mem_we        <= 1'b0;
            mem_waddr     <= '0;
            mem_din       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bytes_written <= '0;
            overflow      <= 1'b0;
`ifdef RESP_ONES_COUNT_EN
            ones_count    <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;

            if (wr_req) begin
                if (ram_full) begin
                    overflow <= 1'b1;
                end else begin
                    mem_we        <= 1'b1;
                    mem_din       <= wr_data;
                    mem_waddr     <= addr;
                    bytes_written <= bytes_written + BwOne;
                    // hold at the last address instead of wrapping onto earlier results
                    if (addr != LastAddr) begin
                        addr <= addr + AddrOne;
                    end
                end
            end

`ifdef RESP_ONES_COUNT_EN
            if (accept && resp_bit) begin
                ones_count <= ones_count + CntOne;
            end
`endif

            unique case (state)
                StIdle: begin
                    if (start) begin
                        num_bits_q    <= num_bits;
                        bit_cnt       <= '0;
                        addr          <= '0;
                        bytes_written <= '0;
                        overflow      <= 1'b0;
                        busy          <= 1'b1;
`ifdef RESP_ONES_COUNT_EN
                        ones_count    <= '0;
`endif
                        if (num_bits == '0) begin
                            state <= StDone;
                        end else begin
                            state      <= StCollect;
                            resp_ready <= 1'b1;
                        end
                    end
                end
                StCollect: begin
                    if (accept) begin
                        bit_cnt <= bit_cnt_next;
                        if (last_bit) begin
                            resp_ready <= 1'b0;
                            state      <= byte_done ? StDone : StFlush;
                        end
                    end
                end
                StFlush: begin
                    state <= StDone;
                end
                StDone: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
